// File: rtl/data_mem_ctrl.sv
// Data-memory responder: word RAM with byte-lane steering, sub-word read-modify-write and load extension.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_t;

  localparam int AW = DEPTH_LOG2 + 2;

  logic [31:0]   mem_r [0:(1 << DEPTH_LOG2) - 1];
  logic [31:0]   rd_word_r;
  state_t        state_r;
  logic          req_ready_r;
  logic          rsp_valid_r;
  logic [31:0]   rsp_rdata_r;
  logic          misalign_err_r;
  logic [AW-1:0] addr_r;
  logic [1:0]    width_r;
  logic          we_r;
  logic          uns_r;
  logic [31:0]   wdata_r;

  logic          misalign_s;
  logic          is_word_s;
  logic          mem_we_s;
  logic          mem_re_s;
  logic [DEPTH_LOG2-1:0] mem_idx_s;
  logic [31:0]   mem_wdata_s;
  logic          unused_addr_s;

  // Select the addressed lane and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] width, input logic uns);
    logic [31:0] sh;
    logic [15:0] hw;
    sh = word >> {off, 3'b000};
    hw = off[1] ? word[31:16] : word[15:0];
    case (width)
      2'b00:   return uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0000, hw} : {{16{hw[15]}}, hw};
      default: return word;
    endcase
  endfunction

  // Merge sub-word store data into the lanes selected by the byte offset.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] off, input logic [1:0] width);
    logic [31:0] mask;
    mask = 32'h000000FF << {off, 3'b000};
    case (width)
      2'b00:   return (word & ~mask) | (({24'h000000, data[7:0]} << {off, 3'b000}) & mask);
      2'b01:   return off[1] ? {data[15:0], word[15:0]} : {word[31:16], data[15:0]};
      default: return data;
    endcase
  endfunction

  assign unused_addr_s = ^req_addr[31:AW];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = (req_width == 2'b11) ||
                      ((req_width == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                      ((req_width == 2'b01) && req_addr[0]);
  assign is_word_s  = (req_width == 2'b10);
`else
  assign misalign_s = 1'b0;
  assign is_word_s  = req_width[1];
`endif

  // RAM port control: full-word stores write directly from IDLE, RMW writes back from READ.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_idx_s   = addr_r[AW-1:2];
    mem_wdata_s = store_merge(rd_word_r, wdata_r, addr_r[1:0], width_r);
    if (rst) begin
      mem_we_s = 1'b0;
      mem_re_s = 1'b0;
    end else if (state_r == IDLE) begin
      mem_idx_s   = req_addr[AW-1:2];
      mem_wdata_s = req_wdata;
      if (req_valid && !misalign_s) begin
        mem_we_s = req_we && is_word_s;
        mem_re_s = !(req_we && is_word_s);
      end else begin
        mem_we_s = 1'b0;
        mem_re_s = 1'b0;
      end
    end else if (state_r == READ) begin
      mem_we_s = we_r;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Synchronous single-port RAM; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= mem_wdata_s;
    end
    if (mem_re_s) begin
      rd_word_r <= mem_r[mem_idx_s];
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      req_ready_r    <= 1'b1;
      rsp_valid_r    <= 1'b0;
      rsp_rdata_r    <= 32'h00000000;
      misalign_err_r <= 1'b0;
    end else begin
      rsp_valid_r    <= 1'b0;
      misalign_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && misalign_s) begin
            misalign_err_r <= 1'b1;
          end else if (req_valid && !(req_we && is_word_s)) begin
            addr_r      <= req_addr[AW-1:0];
            width_r     <= req_width;
            we_r        <= req_we;
            uns_r       <= req_unsigned;
            wdata_r     <= req_wdata;
            req_ready_r <= 1'b0;
            state_r     <= READ;
          end
        end
        READ: begin
          if (we_r) begin
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            rsp_rdata_r <= load_extend(rd_word_r, addr_r[1:0], width_r, uns_r);
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign misalign_err = misalign_err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a byte-addressed reference memory.
module tb_data_mem_ctrl;

  localparam int DL2    = 10;
  localparam int NWORDS = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_width;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [7:0]  mem_b [0:4*NWORDS-1];
  logic [31:0] last_rdata;
  logic [31:0] got;

  data_mem_ctrl #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    case (w)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit misaligned(input logic [1:0] w, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (w == 2'd3) || (w == 2'd2 && a[1:0] != 2'd0) || (w == 2'd1 && a[0]);
`else
    return (w == 2'd3) && (a == 32'hFFFFFFFF) && 1'b0;
`endif
  endfunction

  // Byte address in the reference memory: wrapped word, offset rounded down to access size.
  function automatic int base_of(input logic [31:0] a, input logic [1:0] w);
    int word;
    int off;
    word = int'((a >> 2) % 32'(NWORDS));
    off  = int'(a % 32'd4);
    off  = off - (off % nbytes(w));
    return word * 4 + off;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w,
                                             input logic uns);
    logic [31:0] v;
    int n;
    int b;
    n = nbytes(w);
    b = base_of(a, w);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_b[b + i]) << (8 * i));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    int b;
    b = base_of(a, w);
    for (int i = 0; i < nbytes(w); i++) mem_b[b + i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  // Present a request and return #1 after the accepting edge.
  task automatic issue(input logic we, input logic [1:0] w, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    req_we = we; req_width = w; req_unsigned = uns; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check_eq("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic check_misalign_pulse();
    check_eq("mis_err", {31'd0, misalign_err}, 32'd1);
    check_eq("mis_ready", {31'd0, req_ready}, 32'd1);
    check_eq("mis_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    bit mis;
    mis = misaligned(w, a);
    issue(1'b1, w, 1'b0, a, d);
    if (mis) begin
      check_misalign_pulse();
    end else begin
      check_eq("st_no_mis", {31'd0, misalign_err}, 32'd0);
      if (nbytes(w) == 4) begin
        check_eq("wstore_ready", {31'd0, req_ready}, 32'd1);
      end else begin
        check_eq("sstore_busy", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check_eq("sstore_done", {31'd0, req_ready}, 32'd1);
      end
      model_store(a, w, d);
    end
    check_eq("st_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check_eq("st_rdata_hold", rsp_rdata, last_rdata);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] w, input logic uns,
                         output logic [31:0] val);
    logic [31:0] exp;
    val = last_rdata;
    if (misaligned(w, a)) begin
      issue(1'b0, w, uns, a, 32'd0);
      check_misalign_pulse();
      check_eq("mis_rdata_hold", rsp_rdata, last_rdata);
    end else begin
      exp = model_load(a, w, uns);
      issue(1'b0, w, uns, a, 32'd0);
      check_eq("ld_t1_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("ld_t1_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      check_eq("ld_latency", {31'd0, rsp_valid}, 32'd1);
      check_eq("ld_data", rsp_rdata, exp);
      val = rsp_rdata;
      last_rdata = exp;
      @(posedge clk); #1;
      check_eq("ld_pulse", {31'd0, rsp_valid}, 32'd0);
      check_eq("ld_ready_again", {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; last_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_mis", {31'd0, misalign_err}, 32'd0);
    rst = 1'b0;

    do_store(32'h10, 2'd2, 32'hDEADBEEF);
    do_load(32'h10, 2'd2, 1'b0, got);
    check_eq("dir_word", got, 32'hDEADBEEF);
    do_store(32'h10, 2'd2, 32'h11223344);
    do_store(32'h13, 2'd0, 32'h000000A5);
    do_load(32'h10, 2'd2, 1'b0, got);
    check_eq("dir_rmw", got, 32'hA5223344);
    do_load(32'h13, 2'd0, 1'b0, got);
    check_eq("dir_sbyte", got, 32'hFFFFFFA5);
    do_load(32'h13, 2'd0, 1'b1, got);
    check_eq("dir_ubyte", got, 32'h000000A5);
    do_load(32'h12, 2'd1, 1'b0, got);
    check_eq("dir_shalf", got, 32'hFFFFA522);
    do_store(32'h0, 2'd2, 32'hCAFEF00D);
    do_load(32'(4 << DL2), 2'd2, 1'b0, got);
    check_eq("dir_wrap", got, 32'hCAFEF00D);
    do_load(32'h11, 2'd2, 1'b0, got);
`ifndef MEM_ALIGN_CHECK_EN
    check_eq("dir_unaligned_word", got, 32'hA5223344);
`endif
    do_load(32'h10, 2'd2, 1'b0, got);
    check_eq("dir_ram_intact", got, 32'hA5223344);

    // Reset while a sub-word store sits in READ must drop the write-back.
    do_store(32'h20, 2'd2, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h55);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check_eq("midrst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    last_rdata = 32'd0;
    do_load(32'h20, 2'd2, 1'b0, got);
    check_eq("midrst_ram", got, 32'h11223344);

    for (int i = 0; i < 16; i++) do_store(32'(i * 4), 2'd2, $urandom);
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) << (DL2 + 2)) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        do_store(a, 2'($urandom_range(0, 3)), $urandom);
      else
        do_load(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
